// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath.
// Holds the default width, the FSM state encoding and the MM step length.
package rsa_pkg;

  localparam int WIDTH = 8;

  function automatic int mm_cycles(input int w);
    return 2 * w + 1;
  endfunction

  localparam int MM_CYCLES = mm_cycles(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RED_B = 3'd1,
    TEST  = 3'd2,
    MUL   = 3'd3,
    SQR   = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/mod_reduce_16by8.sv
// Restoring shift-subtract reducer: remainder = dividend mod modulus.
// The start edge performs the first of 2*W iterations; done pulses with the last one.
module mod_reduce_16by8
  import rsa_pkg::*;
#(
  parameter int W = rsa_pkg::WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   modulus,
  output logic           done,
  output logic [W-1:0]   remainder
);

  localparam int ITERS = mm_cycles(W) - 1;
  localparam int CW    = $clog2(ITERS + 1);

  logic [2*W-1:0] dq;
  logic [CW-1:0]  cnt;

  // One restoring step; the W+1-bit trial value keeps the partial remainder below modulus.
  function automatic logic [W-1:0] step(input logic [W-1:0] r, input logic bit_in,
                                        input logic [W-1:0] n);
    logic [W:0] t;
    t = {r, bit_in};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    return t[W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dq        <= '0;
      cnt       <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder <= step('0, dividend[2*W-1], modulus);
        dq        <= dividend << 1;
        cnt       <= CW'(ITERS - 1);
      end else if (cnt != '0) begin
        remainder <= step(remainder, dq[2*W-1], modulus);
        dq        <= dq << 1;
        cnt       <= cnt - 1'b1;
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/modexp_8bit.sv
// Right-to-left binary modular exponentiation: result = base^exp mod modulus.
// MODEXP_EARLY_EXIT_EN stops at the highest set exponent bit instead of scanning all WIDTH bits.
module modexp_8bit #(
  parameter int WIDTH = rsa_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  import rsa_pkg::*;

  state_t             state;
  logic [WIDTH-1:0]   base_q, exp_q, n_q, r_q, b_q;
  logic               err_q;
  logic               mm_issue;
  logic [WIDTH-1:0]   mul_x, mul_y;
  logic [2*WIDTH-1:0] prod;
  logic               red_done;
  logic [WIDTH-1:0]   red_rem;
  logic               test_done, last_bit;

  always_comb begin
    mul_x = r_q;
    mul_y = b_q;
    case (state)
      RED_B:   begin mul_x = base_q; mul_y = WIDTH'(1); end
      SQR:     mul_x = b_q;
      default: ;
    endcase
  end

  assign prod = (2*WIDTH)'(mul_x) * (2*WIDTH)'(mul_y);

  mod_reduce_16by8 #(.W(WIDTH)) u_reduce (
    .clk       (clk),
    .rst       (rst),
    .start     (mm_issue),
    .dividend  (prod),
    .modulus   (n_q),
    .done      (red_done),
    .remainder (red_rem)
  );

`ifdef MODEXP_EARLY_EXIT_EN
  assign test_done = (exp_q == '0);
  assign last_bit  = (exp_q[WIDTH-1:1] == '0);
`else
  localparam int BW = $clog2(WIDTH + 1);
  logic [BW-1:0] bits_left;
  assign test_done = 1'b0;
  assign last_bit  = (bits_left == BW'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
      mm_issue <= 1'b0;
`ifndef MODEXP_EARLY_EXIT_EN
      bits_left <= '0;
`endif
    end else begin
      done     <= 1'b0;
      mm_issue <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exp;
            n_q    <= modulus;
            busy   <= 1'b1;
            result <= '0;
            err    <= 1'b0;
`ifndef MODEXP_EARLY_EXIT_EN
            bits_left <= BW'(WIDTH);
`endif
            if (modulus == '0) begin
              err_q <= 1'b1;
              r_q   <= '0;
              state <= FIN;
            end else begin
              err_q    <= 1'b0;
              // 1 mod n collapses to 0 when n == 1
              r_q      <= (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
              mm_issue <= 1'b1;
              state    <= RED_B;
            end
          end
        end
        RED_B: begin
          if (red_done) begin
            b_q   <= red_rem;
            state <= TEST;
          end
        end
        TEST: begin
          if (test_done) begin
            state <= FIN;
          end else if (exp_q[0]) begin
            mm_issue <= 1'b1;
            state    <= MUL;
          end else if (last_bit) begin
            state <= FIN;
          end else begin
            mm_issue <= 1'b1;
            state    <= SQR;
          end
        end
        MUL: begin
          if (red_done) begin
            r_q <= red_rem;
            if (last_bit) begin
              state <= FIN;
            end else begin
              mm_issue <= 1'b1;
              state    <= SQR;
            end
          end
        end
        SQR: begin
          if (red_done) begin
            b_q   <= red_rem;
            exp_q <= exp_q >> 1;
`ifndef MODEXP_EARLY_EXIT_EN
            bits_left <= bits_left - 1'b1;
`endif
            state <= TEST;
          end
        end
        FIN: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          result <= r_q;
          err    <= err_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_8bit.sv
// Directed bench for modexp_8bit with a scoreboard of expected result/err/latency.
module tb_modexp_8bit;

  import rsa_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] base, exp_i, modulus;
  logic       busy, done, err;
  logic [7:0] result;

  always #5 clk = ~clk;

  modexp_8bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .exp     (exp_i),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  typedef struct {
    logic [7:0] res;
    logic       er;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] model_res(input logic [7:0] b, input logic [7:0] e,
                                           input logic [7:0] n);
    int r, bb;
    if (n == 0) return 8'd0;
    r  = 1 % n;
    bb = b % n;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * bb) % n;
      bb = (bb * bb) % n;
    end
    return 8'(r);
  endfunction

  function automatic int model_lat(input logic [7:0] e, input logic [7:0] n);
    int pop, k;
    if (n == 0) return 2;
    pop = $countones(e);
`ifdef MODEXP_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < 8; i++) if (e[i]) k = i + 1;
`else
    k = 8;
`endif
    return MM_CYCLES + k + MM_CYCLES * pop + MM_CYCLES * (k - 1) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Launch one operation; optionally re-pulse start with other operands at cycle rp.
  task automatic run(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n,
                     input int rp, input string tag);
    exp_t x;
    int   lat, bcyc;
    logic seen;
    @(negedge clk);
    base = b; exp_i = e; modulus = n; start = 1'b1;
    sb.push_back('{model_res(b, e, n), (n == 0), model_lat(e, n)});
    @(posedge clk); #1;
    start = 1'b0;
    base = 8'hA5; exp_i = 8'h3C; modulus = 8'h11;
    bcyc = int'(busy);
    lat  = 0;
    seen = 1'b0;
    while (lat < 400 && !seen) begin
      start = (lat == rp);
      if (lat == rp) begin base = 8'd48; exp_i = 8'd103; modulus = 8'd143; end
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else bcyc += int'(busy);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    x = sb.pop_front();
    check({tag, "_result"}, 32'(result), 32'(x.res));
    check({tag, "_err"}, 32'(err), 32'(x.er));
    if (x.er) begin
      n_cmp++;
      assert (lat <= x.lat && bcyc <= 1) else begin
        n_bad++;
        $error("FAIL %s_err_timing: observed lat %0d busy %0d expected lat<=%0d busy<=1",
               tag, lat, bcyc, x.lat);
      end
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(x.lat));
      check({tag, "_busy_cycles"}, 32'(bcyc), 32'(x.lat));
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_held"}, 32'(result), 32'(x.res));
  endtask

  initial begin
    int cyc;
    logic stray;
    rst = 1'b1; start = 1'b0; base = '0; exp_i = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(8'd9,   8'd7,   8'd143, -1, "encrypt");
    run(8'd48,  8'd103, 8'd143, -1, "decrypt");
    run(8'd200, 8'd1,   8'd143, -1, "unreduced");
    run(8'd5,   8'd0,   8'd143, -1, "exp0");
    run(8'd77,  8'd255, 8'd1,   -1, "n1");
    run(8'd123, 8'd45,  8'd251, -1, "misc");
    run(8'd4,   8'd200, 8'd0,   -1, "n0");
    run(8'd9,   8'd7,   8'd143, 30, "repulse");

    // Abort a run with reset mid-flight; no done may follow.
    @(negedge clk);
    base = 8'd9; exp_i = 8'd7; modulus = 8'd143; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc < 50; cyc++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    rst = 1'b0;
    stray = 1'b0;
    repeat (250) begin
      @(posedge clk); #1;
      if (done || busy) stray = 1'b1;
    end
    check("abort_no_done", 32'(stray), 32'd0);

    run(8'd9, 8'd7, 8'd143, -1, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
